// File: rtl/flashbus_ctrl.sv
// Wishbone front-end for the serial-flash controller: decodes data/control strobes into one-hot
// engine requests and owns the keyed write-protect/erase register, status word and request watchdog.
module flashbus_ctrl #(
  parameter int unsigned AW           = 22,
  parameter int unsigned PAGE_LG      = 6,
  parameter int unsigned SECTOR_LG    = 14,
  parameter int unsigned SUBSECTOR_LG = 10,
  parameter logic [9:0]  KEY          = 10'h1be,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cyc,
  input  logic          i_data_stb,
  input  logic          i_ctrl_stb,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic          o_wb_err,
  output logic [31:0]   o_wb_data,
  output logic          o_wr,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_data,
  output logic          o_readreq,
  output logic          o_piperd,
  output logic          o_wrreq,
  output logic          o_pipewr,
  output logic          o_endwr,
  output logic          o_erreq,
  output logic          o_ctreq,
  output logic          o_idreq,
  output logic [AW-1:0] o_sector,
  output logic          o_subsector,
  input  logic          i_ack,
  input  logic          i_wip,
  input  logic          i_quad,
  input  logic          i_xip,
  input  logic          i_idloaded
);

  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]     WdLoad   = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0]     WdOne    = WDW'(1);
  localparam logic [AW-1:0]      AddrOne  = AW'(1);
  localparam logic [PAGE_LG-1:0] PageOne  = PAGE_LG'(1);
  localparam logic [AW-1:0]      SubMask  = {AW{1'b1}} << SUBSECTOR_LG;
  localparam logic [AW-1:0]      SecMask  = {AW{1'b1}} << SECTOR_LG;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [2:0] {DecLocal, DecErase, DecWel, DecCtrl, DecId, DecRead, DecWrite} dec_e;

  state_e           state;
  dec_e             dec;
  logic             dec_wp_err;
  logic             wp, wp_err, timeout_err;
  logic             is_ctrl, pipe_rd, pipe_wr, last_rd, last_wr, wip_q;
  logic [AW-1:0]    prev_addr, next_addr;
  logic [PAGE_LG-1:0] next_low;
  logic [WDW-1:0]   wdog;
  logic             accept, rd_next, wr_next, status_sel, ctrl_sel;
  logic [4:0]       creg;
  logic [23:0]      sector_ext;

  assign accept     = i_cyc && (i_data_stb || i_ctrl_stb) && !o_wb_stall;
  assign next_addr  = prev_addr + AddrOne;
  assign next_low   = prev_addr[PAGE_LG-1:0] + PageOne;
  assign rd_next    = last_rd && (i_addr == next_addr);
  // A low-bit wrap to zero starts a new page even if the upper bits happen to match.
  assign wr_next    = last_wr && (i_addr[AW-1:PAGE_LG] == prev_addr[AW-1:PAGE_LG])
                      && (i_addr[PAGE_LG-1:0] == next_low) && (next_low != '0);
  assign creg       = o_addr[4:0];
  assign status_sel = is_ctrl && (creg == 5'd0);
  assign ctrl_sel   = ((creg >= 5'd1) && (creg <= 5'd7)) || (creg == 5'd13) || (creg == 5'd14);
  assign sector_ext = 24'(o_sector);
  assign o_wb_data  = {i_wip, ~wp, i_quad, o_subsector, i_idloaded, wp_err, i_xip, timeout_err,
                       sector_ext};

  always_comb begin
    dec        = DecLocal;
    dec_wp_err = 1'b0;
    if (!is_ctrl && i_wip && !(o_wr && pipe_wr)) begin
      dec = DecLocal;
    end else if (status_sel && o_wr) begin
      if ((o_data[31:30] == 2'b11) && (o_data[9:0] == KEY) && !wp) begin
        dec = DecErase;
      end else if (o_data[31]) begin
        dec_wp_err = 1'b1;
      end else if (o_data[30] == wp) begin
        dec = DecWel;
      end
    end else if (status_sel) begin
      dec = DecLocal;
    end else if (is_ctrl) begin
      dec = ctrl_sel ? DecCtrl : DecId;
    end else if (!o_wr) begin
      dec = DecRead;
    end else if (wp) begin
      dec_wp_err = 1'b1;
    end else begin
      dec = DecWrite;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= StIdle;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wb_stall  <= 1'b0;
      o_wr        <= 1'b0;
      o_addr      <= '0;
      o_data      <= '0;
      o_readreq   <= 1'b0;
      o_piperd    <= 1'b0;
      o_wrreq     <= 1'b0;
      o_pipewr    <= 1'b0;
      o_endwr     <= 1'b1;
      o_erreq     <= 1'b0;
      o_ctreq     <= 1'b0;
      o_idreq     <= 1'b0;
      o_sector    <= '0;
      o_subsector <= 1'b0;
      wp          <= 1'b1;
      wp_err      <= 1'b0;
      timeout_err <= 1'b0;
      is_ctrl     <= 1'b0;
      pipe_rd     <= 1'b0;
      pipe_wr     <= 1'b0;
      last_rd     <= 1'b0;
      last_wr     <= 1'b0;
      prev_addr   <= '0;
      wdog        <= '0;
      wip_q       <= 1'b0;
    end else begin
      wip_q    <= i_wip;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if ((state == StIdle) && !i_cyc) o_endwr <= 1'b1;
          state <= StIdle;
          if (accept) begin
            state      <= StIssue;
            o_wb_stall <= 1'b1;
            o_wr       <= i_data_stb ? i_we : i_we;
            o_addr     <= i_addr;
            o_data     <= i_data;
            is_ctrl    <= !i_data_stb;
            pipe_rd    <= i_data_stb && !i_we && rd_next;
            pipe_wr    <= i_data_stb && i_we && wr_next;
            last_rd    <= i_data_stb && !i_we;
            last_wr    <= i_data_stb && i_we;
            prev_addr  <= i_addr;
            if (!(i_data_stb && i_we && wr_next)) o_endwr <= 1'b1;
          end
        end
        StIssue: begin
          state <= StWait;
          wdog  <= WdLoad;
          if (status_sel && o_wr) timeout_err <= 1'b0;
          if (dec_wp_err) wp_err <= 1'b1;
          unique case (dec)
            DecLocal: begin
              state      <= StDone;
              o_wb_ack   <= 1'b1;
              o_wb_stall <= 1'b0;
            end
            DecErase: begin
              o_erreq     <= 1'b1;
              o_subsector <= o_data[28];
              o_sector    <= o_data[AW-1:0] & (o_data[28] ? SubMask : SecMask);
            end
            DecWel: begin
              wp      <= ~o_data[30];
              o_ctreq <= 1'b1;
              wp_err  <= 1'b0;
            end
            DecCtrl: o_ctreq <= 1'b1;
            DecId:   o_idreq <= 1'b1;
            DecRead: begin
              o_readreq <= 1'b1;
              o_piperd  <= pipe_rd;
            end
            DecWrite: begin
              o_wrreq  <= 1'b1;
              o_pipewr <= pipe_wr;
              o_endwr  <= 1'b0;
            end
          endcase
        end
        StWait: begin
          // An engine ack on the expiry cycle still completes normally.
          if (i_ack || (wdog == '0)) begin
            state      <= StDone;
            o_wb_stall <= 1'b0;
            o_readreq  <= 1'b0;
            o_piperd   <= 1'b0;
            o_wrreq    <= 1'b0;
            o_pipewr   <= 1'b0;
            o_erreq    <= 1'b0;
            o_ctreq    <= 1'b0;
            o_idreq    <= 1'b0;
            if (i_ack) begin
              o_wb_ack <= 1'b1;
            end else begin
              o_wb_err    <= 1'b1;
              timeout_err <= 1'b1;
            end
          end else begin
            wdog <= wdog - WdOne;
          end
        end
      endcase
      // Engine finishing an operation clears its write-enable latch.
      if (wip_q && !i_wip) wp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flashbus_ctrl.sv
// Directed bench for flashbus_ctrl with a shortened watchdog (TIMEOUT=8).
module tb_flashbus_ctrl;

  logic        clk = 1'b0;
  logic        rst, cyc, data_stb, ctrl_stb, we;
  logic [21:0] addr;
  logic [31:0] data;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_data;
  logic        wr;
  logic [21:0] laddr;
  logic [31:0] ldata;
  logic        readreq, piperd, wrreq, pipewr, endwr, erreq, ctreq, idreq;
  logic [21:0] sector;
  logic        subsector;
  logic        ack, wip, quad, xip, idloaded;

  int checks = 0;
  int errors = 0;
  logic e0_stall, e0_endwr, e0_ack;

  always #5 clk = ~clk;

  flashbus_ctrl #(.AW(22), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_cyc(cyc), .i_data_stb(data_stb), .i_ctrl_stb(ctrl_stb),
    .i_we(we), .i_addr(addr), .i_data(data),
    .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_err(wb_err), .o_wb_data(wb_data),
    .o_wr(wr), .o_addr(laddr), .o_data(ldata),
    .o_readreq(readreq), .o_piperd(piperd), .o_wrreq(wrreq), .o_pipewr(pipewr),
    .o_endwr(endwr), .o_erreq(erreq), .o_ctreq(ctreq), .o_idreq(idreq),
    .o_sector(sector), .o_subsector(subsector),
    .i_ack(ack), .i_wip(wip), .i_quad(quad), .i_xip(xip), .i_idloaded(idloaded)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one strobe, lets it be accepted, then advances through the ISSUE cycle.
  task automatic req(input logic is_ctrl, input logic w, input logic [21:0] a,
                     input logic [31:0] d);
    data_stb = !is_ctrl;
    ctrl_stb = is_ctrl;
    we       = w;
    addr     = a;
    data     = d;
    tick();
    data_stb = 1'b0;
    ctrl_stb = 1'b0;
    e0_stall = wb_stall;
    e0_endwr = endwr;
    e0_ack   = wb_ack;
    tick();
  endtask

  task automatic finish_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_ack"}, 32'({wb_ack, wb_err, readreq, wrreq, erreq, ctreq, idreq}),
          32'b1000000);
    tick();
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b1; data_stb = 1'b0; ctrl_stb = 1'b0; we = 1'b0;
    addr = '0; data = '0; ack = 1'b0; wip = 1'b0; quad = 1'b0; xip = 1'b0; idloaded = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_outs", 32'({wb_ack, wb_stall, wb_err, endwr, readreq, wrreq, erreq, ctreq}),
          32'b00010000);
    check("rst_status", wb_data, 32'h0000_0000);

    // Status read is acked locally two cycles after acceptance.
    req(1'b1, 1'b0, 22'h0, 32'h0);
    check("sr_e0", 32'({e0_stall, e0_ack}), 32'b10);
    check("sr_ack", 32'({wb_ack, wb_stall, ctreq}), 32'b100);
    tick();
    check("sr_ack_drop", 32'(wb_ack), 32'd0);

    // Unlock: WEL change goes to the engine and holds until acknowledged.
    req(1'b1, 1'b1, 22'h0, 32'h4000_0000);
    check("wel_req", 32'(ctreq), 32'd1);
    tick();
    check("wel_hold", 32'({ctreq, wb_ack}), 32'b10);
    finish_ack("wel");
    req(1'b1, 1'b0, 22'h0, 32'h0);
    check("sr_unlocked", wb_data, 32'h4000_0000);
    tick();

    // Program burst with a page crossing.
    req(1'b0, 1'b1, 22'h40, 32'h1234_5678);
    check("wr40", 32'({wrreq, pipewr, endwr, wr}), 32'b1001);
    check("wr40_latch", 32'(laddr), 32'h40);
    check("wr40_data", ldata, 32'h1234_5678);
    finish_ack("wr40");
    req(1'b0, 1'b1, 22'h41, 32'h0);
    check("wr41", 32'({e0_endwr, wrreq, pipewr, endwr}), 32'b0110);
    finish_ack("wr41");
    req(1'b0, 1'b1, 22'h7F, 32'h0);
    check("wr7f", 32'({wrreq, pipewr}), 32'b10);
    finish_ack("wr7f");
    req(1'b0, 1'b1, 22'h80, 32'h0);
    check("wr80", 32'({e0_endwr, wrreq, pipewr, endwr}), 32'b1100);
    finish_ack("wr80");

    // Keyed subsector erase while unlocked.
    req(1'b1, 1'b1, 22'h0, 32'hD012_3DBE);
    check("erase", 32'({erreq, subsector, ctreq}), 32'b110);
    check("erase_sector", 32'(sector), 32'h0012_3C00);
    finish_ack("erase");
    check("erase_status", wb_data, 32'h5012_3C00);

    // Relock, then the same erase is refused locally and flags wp_err.
    req(1'b1, 1'b1, 22'h0, 32'h0000_0000);
    check("relock", 32'(ctreq), 32'd1);
    finish_ack("relock");
    req(1'b1, 1'b1, 22'h0, 32'hD012_3DBE);
    check("erase_locked", 32'({wb_ack, erreq}), 32'b10);
    check("erase_locked_sr", wb_data, 32'h1412_3C00);
    tick();

    // Pipelined reads broken by a control access.
    req(1'b0, 1'b0, 22'h10, 32'h0);
    check("rd10", 32'({readreq, piperd}), 32'b10);
    finish_ack("rd10");
    req(1'b0, 1'b0, 22'h11, 32'h0);
    check("rd11", 32'({readreq, piperd}), 32'b11);
    finish_ack("rd11");
    req(1'b1, 1'b0, 22'h8, 32'h0);
    check("id_req", 32'({idreq, ctreq}), 32'b10);
    finish_ack("id");
    req(1'b0, 1'b0, 22'h12, 32'h0);
    check("rd12", 32'({readreq, piperd}), 32'b10);
    finish_ack("rd12");

    // Watchdog expiry with no engine ack.
    req(1'b0, 1'b0, 22'h200, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("wd_hold", 32'({readreq, wb_err}), 32'b10);
    end
    tick();
    check("wd_expire", 32'({readreq, wb_err, wb_ack}), 32'b010);
    tick();
    check("wd_status", wb_data, 32'h1512_3C00);

    // Engine ack on the expiry cycle wins.
    req(1'b0, 1'b0, 22'h300, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("wd_race", 32'({wb_ack, wb_err, readreq}), 32'b100);
    tick();
    check("wd_sticky", 32'(wb_data[24]), 32'd1);

    // Busy engine: data access acked locally; falling wip relocks.
    wip = 1'b1;
    req(1'b0, 1'b0, 22'h400, 32'h0);
    check("wip_local", 32'({wb_ack, readreq}), 32'b10);
    tick();
    req(1'b1, 1'b1, 22'h0, 32'h4000_0000);
    finish_ack("wip_wel");
    check("wip_status", wb_data, 32'hD012_3C00);
    wip = 1'b0;
    tick();
    check("wip_fall", wb_data, 32'h1012_3C00);

    // Reset in the middle of a request drops it without an ack.
    req(1'b0, 1'b0, 22'h500, 32'h0);
    check("mid_req", 32'(readreq), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst", 32'({readreq, wb_stall, wb_ack, wb_err}), 32'b0000);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("mid_noack", 32'({wb_ack, wb_err}), 32'b00);
    check("mid_status", wb_data, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flashbus_ctrl.md
Name: flashbus_ctrl

Overview:
- Parametrised Wishbone front-end for the serial-flash controller. Accepts data-space and control-space strobes, then issues one-hot request lines: read, write, erase, control and ID.
- Decodes pipelined reads and same-page program bursts.
- Implements a keyed write-protect/erase register and a status word.
- Adds a request watchdog that errors a bus cycle the flash engine never acknowledges.

Parameters:
- AW, 22, word-address width (10..24).
- PAGE_LG, 6, log2 words per program page.
- SECTOR_LG, 14, log2 words per erase sector.
- SUBSECTOR_LG, 10, log2 words per subsector (>=10, <SECTOR_LG).
- KEY, 10'h1be, erase/unlock key compared against data[9:0].
- TIMEOUT, 4096, cycles from request issue to forced error (>=4).

Ports:
- i_clk in 1 clock.
- i_rst in 1 reset.
- i_cyc, i_data_stb, i_ctrl_stb, i_we in 1 each: Wishbone cycle, strobes and write enable.
- i_addr in AW, word address.
- i_data in 32, write data.
- o_wb_ack, o_wb_stall, o_wb_err out 1 each.
- o_wb_data out 32, status word.
- o_wr out 1, latched write enable.
- o_addr out AW, latched address.
- o_data out 32, latched data.
- o_readreq, o_piperd, o_wrreq, o_pipewr, o_endwr, o_erreq, o_ctreq, o_idreq out 1 each: request lines to the flash engine.
- o_sector out AW, erase address.
- o_subsector out 1, erase granularity.
- i_ack in 1, flash engine done.
- i_wip, i_quad, i_xip, i_idloaded in 1 each, engine status.

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk.
- Reset values:
  - All request outputs, o_wb_ack, o_wb_err, o_wb_stall, wp_err and timeout_err = 0.
  - wp = 1, o_endwr = 1.
  - o_sector = 0, o_subsector = 0.
- Reset mid-transaction drops the request and never acks it.
- FSM IDLE, ISSUE, WAIT, DONE:
  - IDLE: a strobe with o_wb_stall=0 is accepted. o_addr, o_data and o_wr are latched, and o_wb_stall=1 from the next cycle. Go to ISSUE.
  - ISSUE (1 cycle): decode and assert exactly one request line (held), or schedule a local ack. Go to WAIT, or to DONE for a local ack.
  - WAIT: i_ack goes to DONE and clears all request lines next cycle. Watchdog reaching 0 goes to DONE with error.
  - DONE: o_wb_ack (or o_wb_err) pulses 1 cycle, o_wb_stall=0, back to IDLE.
- Minimum latency is strobe to ack = 3 cycles after i_ack.
- A strobe presented while stalled is ignored.
- If both strobes are high, i_data_stb wins.
- Decode priority at ISSUE:
  1. Data read or write while i_wip=1 and the access is not pipewr: local ack, nothing forwarded.
  2. Ctrl addr[4:0]==0 (status register) write:
     - data[31:30]==2'b11, data[9:0]==KEY and wp==0: o_erreq. o_subsector=data[28]. o_sector=data[AW-1:0] with the low SUBSECTOR_LG bits cleared if data[28], else the low SECTOR_LG bits.
     - data[31]==1 otherwise: local ack, wp_err<=1.
     - data[31]==0 and data[30]==wp: wp<=~data[30], o_ctreq (WEL change), wp_err<=0.
     - data[31]==0 and data[30]!=wp: local ack.
  3. Status register read: local ack.
  4. Ctrl addr[4:0] 1..7, 13, 14: o_ctreq. Any other ctrl addr: o_idreq.
  5. Data read: o_readreq.
  6. Data write: wp=1 gives local ack and wp_err<=1; wp=0 gives o_wrreq and o_endwr<=0.
- o_piperd=1 with o_readreq iff the previous accepted transaction was a data read, no ctrl access intervened, and i_addr==previous+1 (AW-bit wrap).
- o_pipewr=1 with o_wrreq iff the previous accepted transaction was a data write, addr[AW-1:PAGE_LG] is equal, and addr[PAGE_LG-1:0]==previous+1. A low-bit wrap to 0 is a new page, so not pipeable.
- o_endwr<=1 in IDLE when i_cyc=0, or when an accepted request is not pipewr.
- A falling edge of i_wip sets wp<=1.
- Watchdog:
  - Loaded with TIMEOUT-1 at ISSUE, decrements in WAIT.
  - At 0: all request lines drop, timeout_err<=1 (sticky until the next status-register write), o_wb_err pulses, and no ack is given.
  - An i_ack arriving on the same cycle as expiry wins (normal ack).
- o_wb_data = {i_wip, ~wp, i_quad, o_subsector, i_idloaded, wp_err, i_xip, timeout_err, o_sector zero-extended to 24 bits}. Driven combinationally at all times.

Test Plan:
- Reset, then read status -> ack 2 cycles after accept; o_wb_data[31:24]=8'h00; wp=1, so ~wp=0 at bit 30.
- Status write 32'h4000_0000 -> o_ctreq until i_ack; then the status read shows bit30=1. Write data to 0x000040 -> o_wrreq=1, o_pipewr=0, o_endwr=0.
- After unlock, writes to 0x41 then 0x7F->0x80 -> 0x41 has pipewr=1; 0x80 has pipewr=0 (page wrap) and o_endwr pulses.
- Erase write {2'b11,1'b0,1'b1,6'h0,22'h0123C00}|KEY with wp=0 -> o_erreq=1, o_subsector=1, o_sector=22'h0123C00. Same write with wp=1 -> local ack, status bit26=1, no o_erreq.
- Reads at 0x10, 0x11, then ctrl read, then 0x12 -> o_piperd=0, 1, 0.
- TIMEOUT=8 with i_ack held low -> o_readreq drops and o_wb_err pulses at the 8th WAIT cycle, status bit24=1. Repeat with i_ack at the expiry cycle -> o_wb_ack, no error.
